// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle execute-stage ALU.
//   ALU_CTRL_W      width of the operation select
//   ALU_* opcodes   3-bit operation encodings driven on ALUCtrl_i
//   state_e         control FSM states (IDLE, MUL)
package alu_mc_pkg;

    localparam int ALU_CTRL_W = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_NOP = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b100;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 3'b101;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, MUL_STEP multiplier bits per cycle.
//   clk, rst_n   clock / async active-low reset
//   start        load operands, clear accumulator, arm the step counter
//   run          perform one step this cycle (owner's FSM is in MUL)
//   a, b         multiplicand / multiplier, sampled on start
//   done         this cycle's step is the last one; product is final
//   product      low WIDTH bits of the running product after this step
//   hi_nz        (ALU_MC_OVF_EN only) upper WIDTH product bits are non-zero
// With ALU_MC_OVF_EN the accumulator is 2*WIDTH wide so the upper half of the
// product is available; otherwise only the low half is kept.
module alu_mul_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
`ifdef ALU_MC_OVF_EN
    output logic             hi_nz,
`endif
    output logic [WIDTH-1:0] product
);

    localparam int ITERS = WIDTH / MUL_STEP;
    localparam int CNT_W = $clog2(ITERS + 1);
`ifdef ALU_MC_OVF_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif

    logic [ACC_W-1:0] acc_q, a_q, partial, acc_nxt;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;

    // Partial product of the low MUL_STEP multiplier bits; a_q is already
    // shifted into position, so no extra alignment is needed here.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (b_q[i]) partial = partial + (a_q << i);
        end
        acc_nxt = acc_q + partial;
    end

    assign done    = run && (cnt_q == CNT_W'(1));
    assign product = acc_nxt[WIDTH-1:0];
`ifdef ALU_MC_OVF_EN
    assign hi_nz   = |acc_nxt[ACC_W-1:WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (start) begin
            acc_q <= '0;
            a_q   <= ACC_W'(a);
            b_q   <= b;
            cnt_q <= CNT_W'(ITERS);
        end else if (run) begin
            acc_q <= acc_nxt;
            a_q   <= a_q << MUL_STEP;
            b_q   <= b_q >> MUL_STEP;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready on both sides.
//   clk_i, rst_n_i          clock / async active-low reset
//   in_valid_i, in_ready_o  operation handshake (in_ready_o is combinational
//                           from out_ready_i so back-to-back issue is bubble-free)
//   data1_i, data2_i        operands A, B
//   ALUCtrl_i               operation select (alu_mc_pkg opcodes)
//   out_valid_o, out_ready_i result handshake; one-entry output register
//   data_o, Zero_o          result and (result == 0), registered together
//   Overflow_o              present only with `define ALU_MC_OVF_EN: signed
//                           overflow for add/sub, non-zero upper product for mul
// Non-mul ops complete in one cycle; mul runs WIDTH/MUL_STEP cycles in alu_mul_iter.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH-1:0]      data1_i,
    input  logic [WIDTH-1:0]      data2_i,
    input  logic [ALU_CTRL_W-1:0] ALUCtrl_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WIDTH-1:0]      data_o,
`ifdef ALU_MC_OVF_EN
    output logic                  Overflow_o,
`endif
    output logic                  Zero_o
);

    state_e           state_q;
    logic             accept, is_mul, mul_done;
    logic [WIDTH-1:0] sum, diff, res, mul_prod;
`ifdef ALU_MC_OVF_EN
    logic             ovf, mul_hi_nz;
`endif

    assign in_ready_o = (state_q == IDLE) && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign is_mul     = (ALUCtrl_i == ALU_MUL);

    assign sum  = data1_i + data2_i;
    assign diff = data1_i - data2_i;

    always_comb begin
        res = '0;
        unique case (ALUCtrl_i)
            ALU_ADD: res = sum;
            ALU_SUB: res = diff;
            ALU_AND: res = data1_i & data2_i;
            ALU_OR:  res = data1_i | data2_i;
            ALU_XOR: res = data1_i ^ data2_i;
            ALU_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            default: res = '0;  // ALU_NOP; ALU_MUL is produced by the multiplier
        endcase
    end

`ifdef ALU_MC_OVF_EN
    // Signed overflow: operands' signs make the true result unrepresentable.
    always_comb begin
        ovf = 1'b0;
        if (ALUCtrl_i == ALU_ADD)
            ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (sum[WIDTH-1] != data1_i[WIDTH-1]);
        else if (ALUCtrl_i == ALU_SUB)
            ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (diff[WIDTH-1] != data1_i[WIDTH-1]);
    end
`endif

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .start   (accept && is_mul),
        .run     (state_q == MUL),
        .a       (data1_i),
        .b       (data2_i),
        .done    (mul_done),
`ifdef ALU_MC_OVF_EN
        .hi_nz   (mul_hi_nz),
`endif
        .product (mul_prod)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept && is_mul) state_q <= MUL;
                MUL:     if (mul_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output register. A mul can only be accepted when the register is free
    // or draining, so mul completion never collides with an unread result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            data_o      <= '0;
            Zero_o      <= 1'b1;
`ifdef ALU_MC_OVF_EN
            Overflow_o  <= 1'b0;
`endif
        end else if (accept && !is_mul) begin
            out_valid_o <= 1'b1;
            data_o      <= res;
            Zero_o      <= (res == '0);
`ifdef ALU_MC_OVF_EN
            Overflow_o  <= ovf;
`endif
        end else if (mul_done) begin
            out_valid_o <= 1'b1;
            data_o      <= mul_prod;
            Zero_o      <= (mul_prod == '0);
`ifdef ALU_MC_OVF_EN
            Overflow_o  <= mul_hi_nz;
`endif
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0, out_ready = 1;
    logic [31:0] a = 0, b = 0;
    logic [2:0]  ctrl = 0;
    logic        in_ready, out_valid, zero;
    logic [31:0] data;
`ifdef ALU_MC_OVF_EN
    logic        ovf, ovf16;
`endif

    logic        v16 = 0, rdy16 = 1;
    logic [15:0] a16 = 0, b16 = 0;
    logic [2:0]  c16 = 0;
    logic        in_ready16, out_valid16, zero16;
    logic [15:0] data16;

    int total = 0, bad = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .MUL_STEP(1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data1_i(a), .data2_i(b), .ALUCtrl_i(ctrl), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .data_o(data),
`ifdef ALU_MC_OVF_EN
        .Overflow_o(ovf),
`endif
        .Zero_o(zero));

    alu_mc #(.WIDTH(16), .MUL_STEP(4)) u_dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(v16), .in_ready_o(in_ready16),
        .data1_i(a16), .data2_i(b16), .ALUCtrl_i(c16), .out_valid_o(out_valid16),
        .out_ready_i(rdy16), .data_o(data16),
`ifdef ALU_MC_OVF_EN
        .Overflow_o(ovf16),
`endif
        .Zero_o(zero16));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: {overflow, result} from plain arithmetic on 32-bit operands.
    function automatic logic [32:0] ref_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned p  = longint'(x) * longint'(y);
        longint          s;
        case (c)
            3'd1: begin s = sx + sy; return {(s > 64'sd2147483647) || (s < -64'sd2147483648), x + y}; end
            3'd2: begin s = sx - sy; return {(s > 64'sd2147483647) || (s < -64'sd2147483648), x - y}; end
            3'd3: return {1'b0, x & y};
            3'd4: return {1'b0, x | y};
            3'd5: return {(p >> 32) != 0, p[31:0]};
            3'd6: return {1'b0, x ^ y};
            3'd7: return {1'b0, 31'd0, (sx < sy)};
            default: return 33'd0;
        endcase
    endfunction

    // Behavioural model: output slot plus a pending multiply with a cycle countdown.
    logic        m_vld, m_ovf, m_povf;
    logic [31:0] m_data, m_pdata;
    int          m_pend;
    wire         m_in_ready = (m_pend == 0) && (!m_vld || out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= 0; m_data <= 0; m_ovf <= 0; m_pend <= 0; m_pdata <= 0; m_povf <= 0;
        end else begin : upd
            automatic logic        nv = m_vld, no = m_ovf;
            automatic logic [31:0] nd = m_data;
            automatic int          np = m_pend;
            automatic logic [32:0] r;
            if (m_vld && out_ready) nv = 0;
            if (m_pend != 0) begin
                np = m_pend - 1;
                if (np == 0) begin nv = 1; nd = m_pdata; no = m_povf; end
            end
            if (in_valid && m_in_ready) begin
                r = ref_op(ctrl, a, b);
                if (ctrl == 3'd5) begin
                    np = 32;
                    m_pdata <= r[31:0];
                    m_povf  <= r[32];
                end else begin
                    nv = 1; nd = r[31:0]; no = r[32];
                end
            end
            m_vld <= nv; m_data <= nd; m_ovf <= no; m_pend <= np;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_vld);
            check("in_ready", in_ready, m_in_ready);
            if (m_vld) begin
                check("data", data, m_data);
                check("zero", zero, m_data == 0);
`ifdef ALU_MC_OVF_EN
                check("ovf", ovf, m_ovf);
`endif
            end
        end
    end

    // Present one op and hold it until accepted; returns 1 ns after the accept edge.
    task automatic issue(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        ctrl = c; a = x; b = y; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("issue_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    function automatic logic [31:0] pick;
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        bit acc_seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", data, 0);
        check("rst_zero", zero, 1);
        check("rst_ready", in_ready, 1);
        rst_n = 1;
        chk_en = 1;
        @(posedge clk); #1;

        issue(3'd1, 32'd5, 32'd3);
        check("add_valid", out_valid, 1);
        check("add_data", data, 32'd8);
        check("add_zero", zero, 0);

        issue(3'd2, 32'd7, 32'd7);
        check("sub_data", data, 0);
        check("sub_zero", zero, 1);
        check("b2b_ready", in_ready, 1);
        issue(3'd7, 32'hFFFF_FFFF, 32'd1);
        check("slt_data", data, 32'd1);
        check("slt_valid", out_valid, 1);

        issue(3'd5, 32'h0001_0003, 32'h0000_0010);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin n++; @(negedge clk); end
        check("mul_busy_cycles", n, 32);
        check("mul_data", data, 32'h0010_0030);
`ifdef ALU_MC_OVF_EN
        check("mul_ovf", ovf, 0);
`endif
        @(posedge clk); #1;
        issue(3'd5, 32'h8000_0000, 32'd2);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        check("mul2_data", data, 0);
        check("mul2_zero", zero, 1);
`ifdef ALU_MC_OVF_EN
        check("mul2_ovf", ovf, 1);
`endif

        @(posedge clk); #1;
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 0;
        issue(3'd1, 32'hFFFF_FFFF, 32'd1);
        ctrl = 3'd1; a = 32'd1; b = 32'd1; in_valid = 1;
        repeat (5) begin
            @(negedge clk);
            check("hold_data", data, 0);
            check("hold_zero", zero, 1);
            check("hold_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        check("drain_load_valid", out_valid, 1);
        check("drain_load_data", data, 32'd2);

        issue(3'd5, 32'h1234_5678, 32'h0000_0003);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_data", data, 0);
        @(posedge clk); #1;
        rst_n = 1;
        check("rstmid_ready", in_ready, 1);
        repeat (40) @(posedge clk);
        #1;
        check("rstmid_no_result", out_valid, 0);

        c16 = 3'd5; a16 = 16'h00FF; b16 = 16'h0101; v16 = 1;
        @(negedge clk);
        check("w16_ready", in_ready16, 1);
        @(posedge clk); #1;
        v16 = 0;
        n = 0;
        @(negedge clk);
        while (!in_ready16 && n < 50) begin n++; @(negedge clk); end
        check("w16_busy_cycles", n, 4);
        check("w16_valid", out_valid16, 1);
        check("w16_data", data16, 16'hFFFF);
        check("w16_zero", zero16, 0);
`ifdef ALU_MC_OVF_EN
        check("w16_ovf", ovf16, 0);
`endif

        acc_seen = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (acc_seen) begin in_valid = 0; acc_seen = 0; end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                ctrl = 3'($urandom_range(0, 7));
                a = pick();
                b = pick();
                in_valid = 1;
            end
            @(negedge clk);
            acc_seen = in_valid && in_ready;
        end
        @(posedge clk); #1;
        in_valid = 0;
        out_ready = 1;
        repeat (40) @(posedge clk);
        #1;
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
